// File: rtl/bounded_counter_pkg.sv
// Shared types for the bounded_counter block: overflow modes and FSM states.
package counter_pkg;

  typedef enum logic [1:0] {
    CNT_WRAP    = 2'd0,
    CNT_SAT     = 2'd1,
    CNT_ONESHOT = 2'd2
  } cnt_mode_e;

  typedef enum logic {
    CNT_RUN  = 1'b0,
    CNT_DONE = 1'b1
  } cnt_state_e;

endpackage

// File: rtl/bounded_counter_step_calc.sv
// bounded_step_calc: combinational step evaluation for bounded_counter.
//   count, step, min, max : current count, step size, bounds
//   up                    : 1 = count up, 0 = count down
//   mode                  : overflow mode (3 behaves as wrap)
//   next_count            : value to load when a step is taken
//   bound_evt             : step would leave [min, max]
//   tc_qual               : a taken step should raise the terminal-count pulse
module bounded_step_calc
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned STEP_WIDTH = 4
) (
  input  logic [WIDTH-1:0]      count,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [WIDTH-1:0]      min,
  input  logic [WIDTH-1:0]      max,
  input  logic                  up,
  input  logic [1:0]            mode,
  output logic [WIDTH-1:0]      next_count,
  output logic                  bound_evt,
  output logic                  tc_qual
);

  // One guard bit above the wider operand so sums never wrap silently.
  localparam int unsigned AW = ((WIDTH > STEP_WIDTH) ? WIDTH : STEP_WIDTH) + 1;

  logic [AW-1:0] count_x;
  logic [AW-1:0] step_x;
  logic [AW-1:0] min_x;
  logic [AW-1:0] max_x;
  logic [AW-1:0] sum;
  logic [AW-1:0] diff;

  assign count_x = AW'(count);
  assign step_x  = AW'(step);
  assign min_x   = AW'(min);
  assign max_x   = AW'(max);
  assign sum     = count_x + step_x;
  assign diff    = count_x - step_x;

  // Down check is phrased as count < min + step to avoid borrow below zero.
  assign bound_evt = up ? (sum > max_x) : (count_x < (min_x + step_x));

  always_comb begin
    next_count = WIDTH'(up ? sum : diff);
    tc_qual    = 1'b0;
    if (bound_evt) begin
      case (mode)
        CNT_SAT: begin
          next_count = up ? max : min;
          tc_qual    = (count != (up ? max : min));
        end
        CNT_ONESHOT: begin
          next_count = count;
          tc_qual    = 1'b1;
        end
        default: begin
          next_count = up ? min : max;
          tc_qual    = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/bounded_counter.sv
// bounded_counter: up/down counter with programmable bounds, step and
// overflow mode (wrap / saturate / one-shot).
//   clk_i, rst_i        : clock, async active-high reset
//   clear_i, load_en_i  : restart to start bound / load load_count_i
//   en_i, up_down_i     : count enable, direction
//   step_i, min_i, max_i, mode_i : step and bound configuration
//   count_o, tc_o, done_o        : registered count, tc pulse, one-shot done
//   at_bound_o, cfg_err_o        : combinational bound / config status
module bounded_counter
  import counter_pkg::*;
#(
  parameter int unsigned       WIDTH      = 8,
  parameter int unsigned       STEP_WIDTH = 4,
  parameter logic [WIDTH-1:0]  RST_VALUE  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic                  up_down_i,
  input  logic                  load_en_i,
  input  logic [WIDTH-1:0]      load_count_i,
  input  logic [STEP_WIDTH-1:0] step_i,
  input  logic [WIDTH-1:0]      min_i,
  input  logic [WIDTH-1:0]      max_i,
  input  logic [1:0]            mode_i,
  output logic [WIDTH-1:0]      count_o,
  output logic                  tc_o,
  output logic                  done_o,
  output logic                  at_bound_o,
  output logic                  cfg_err_o
);

  cnt_state_e       state;
  cnt_state_e       state_nxt;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nxt;
  logic             tc;
  logic             tc_nxt;

  logic [WIDTH-1:0] step_count;
  logic             bound_evt;
  logic             tc_qual;
  logic             step_ok;

  bounded_step_calc #(
    .WIDTH      (WIDTH),
    .STEP_WIDTH (STEP_WIDTH)
  ) u_step_calc (
    .count      (count),
    .step       (step_i),
    .min        (min_i),
    .max        (max_i),
    .up         (up_down_i),
    .mode       (mode_i),
    .next_count (step_count),
    .bound_evt  (bound_evt),
    .tc_qual    (tc_qual)
  );

  assign cfg_err_o = (min_i > max_i);
  assign step_ok   = en_i && (state == CNT_RUN) && !cfg_err_o && (step_i != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= CNT_RUN;
      count <= RST_VALUE;
      tc    <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      tc    <= tc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    tc_nxt    = 1'b0;
    if (clear_i) begin
      count_nxt = up_down_i ? min_i : max_i;
      state_nxt = CNT_RUN;
    end else if (load_en_i) begin
      count_nxt = load_count_i;
      state_nxt = CNT_RUN;
    end else if (step_ok) begin
      count_nxt = step_count;
      tc_nxt    = tc_qual;
      if (bound_evt && (mode_i == CNT_ONESHOT)) begin
        state_nxt = CNT_DONE;
      end
    end
  end

  assign count_o    = count;
  assign tc_o       = tc;
  assign done_o     = (state == CNT_DONE);
  assign at_bound_o = up_down_i ? (count == max_i) : (count == min_i);

endmodule

// File: tb/tb_bounded_counter.sv
module tb_bounded_counter;

  localparam int unsigned W  = 4;
  localparam int unsigned SW = 3;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          clear_i;
  logic          en_i;
  logic          up_down_i;
  logic          load_en_i;
  logic [W-1:0]  load_count_i;
  logic [SW-1:0] step_i;
  logic [W-1:0]  min_i;
  logic [W-1:0]  max_i;
  logic [1:0]    mode_i;
  logic [W-1:0]  count_o;
  logic          tc_o;
  logic          done_o;
  logic          at_bound_o;
  logic          cfg_err_o;

  int checks = 0;
  int errors = 0;

  int m_count = 0;
  int m_tc    = 0;
  int m_done  = 0;
  bit m_valid = 1'b0;

  bounded_counter #(
    .WIDTH      (W),
    .STEP_WIDTH (SW),
    .RST_VALUE  (4'd0)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .en_i         (en_i),
    .up_down_i    (up_down_i),
    .load_en_i    (load_en_i),
    .load_count_i (load_count_i),
    .step_i       (step_i),
    .min_i        (min_i),
    .max_i        (max_i),
    .mode_i       (mode_i),
    .count_o      (count_o),
    .tc_o         (tc_o),
    .done_o       (done_o),
    .at_bound_o   (at_bound_o),
    .cfg_err_o    (cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the counting rules.
  always @(posedge clk_i or posedge rst_i) begin
    int lo, hi, st, tgt;
    lo = int'(min_i);
    hi = int'(max_i);
    st = int'(step_i);
    if (rst_i) begin
      m_count = 0;
      m_tc    = 0;
      m_done  = 0;
      m_valid = 1'b1;
    end else if (clear_i) begin
      m_count = up_down_i ? lo : hi;
      m_tc    = 0;
      m_done  = 0;
    end else if (load_en_i) begin
      m_count = int'(load_count_i);
      m_tc    = 0;
      m_done  = 0;
    end else if (en_i && m_done == 0 && lo <= hi && st != 0) begin
      tgt = up_down_i ? m_count + st : m_count - st;
      if (up_down_i ? (tgt > hi) : (tgt < lo)) begin
        if (mode_i == 2'd1) begin
          m_tc    = (m_count != (up_down_i ? hi : lo)) ? 1 : 0;
          m_count = up_down_i ? hi : lo;
        end else if (mode_i == 2'd2) begin
          m_tc   = 1;
          m_done = 1;
        end else begin
          m_tc    = 1;
          m_count = up_down_i ? lo : hi;
        end
      end else begin
        m_count = tgt;
        m_tc    = 0;
      end
    end else begin
      m_tc = 0;
    end
    #2;
    if (m_valid) begin
      chk("model_count", int'(count_o), m_count);
      chk("model_tc", int'(tc_o), m_tc);
      chk("model_done", int'(done_o), m_done);
      chk("model_at_bound", int'(at_bound_o),
          (up_down_i ? (m_count == int'(max_i)) : (m_count == int'(min_i))) ? 1 : 0);
      chk("model_cfg_err", int'(cfg_err_o), (int'(min_i) > int'(max_i)) ? 1 : 0);
    end
  end

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic expect_out(input string name, input int c, input int tc, input int dn);
    chk({name, "_count"}, int'(count_o), c);
    chk({name, "_tc"}, int'(tc_o), tc);
    chk({name, "_done"}, int'(done_o), dn);
  endtask

  task automatic cfg(input int mode, input int up, input int lo, input int hi, input int st);
    mode_i    = 2'(mode);
    up_down_i = 1'(up);
    min_i     = W'(lo);
    max_i     = W'(hi);
    step_i    = SW'(st);
  endtask

  task automatic load(input int v);
    load_count_i = W'(v);
    load_en_i    = 1'b1;
    cyc();
    load_en_i    = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; en_i = 1'b0; up_down_i = 1'b1; load_en_i = 1'b0;
    load_count_i = '0; step_i = '0; min_i = '0; max_i = '0; mode_i = '0;
    cyc(); cyc();
    expect_out("reset", 0, 0, 0);
    rst_i = 1'b0;

    // Wrap up: 2 -> 5 -> 8 -> wrap to 2
    cfg(0, 1, 2, 9, 3);
    load(2);
    expect_out("wrap_load", 2, 0, 0);
    en_i = 1'b1;
    cyc(); expect_out("wrap_s1", 5, 0, 0);
    cyc(); expect_out("wrap_s2", 8, 0, 0);
    cyc(); expect_out("wrap_s3", 2, 1, 0);
    en_i = 1'b0;
    cyc(); expect_out("wrap_idle", 2, 0, 0);

    // Saturate down: 12 -> 8 -> 4 -> 3 (tc), then clamp silently
    cfg(1, 0, 3, 12, 4);
    load(12);
    expect_out("sat_load", 12, 0, 0);
    en_i = 1'b1;
    cyc(); expect_out("sat_s1", 8, 0, 0);
    cyc(); expect_out("sat_s2", 4, 0, 0);
    cyc(); expect_out("sat_s3", 3, 1, 0);
    chk("sat_at_bound", int'(at_bound_o), 1);
    cyc(); expect_out("sat_s4", 3, 0, 0);
    cyc(); expect_out("sat_s5", 3, 0, 0);
    en_i = 1'b0;

    // One-shot up
    cfg(2, 1, 0, 15, 5);
    clear_i = 1'b1;
    cyc(); expect_out("os_clear", 0, 0, 0);
    clear_i = 1'b0;
    en_i = 1'b1;
    cyc(); expect_out("os_s1", 5, 0, 0);
    cyc(); expect_out("os_s2", 10, 0, 0);
    cyc(); expect_out("os_s3", 15, 0, 0);
    chk("os_at_bound", int'(at_bound_o), 1);
    cyc(); expect_out("os_s4", 15, 1, 1);
    cyc(); expect_out("os_hold", 15, 0, 1);
    clear_i = 1'b1;
    cyc(); expect_out("os_reclear", 0, 0, 0);
    clear_i = 1'b0;
    en_i = 1'b0;
    cyc();

    // Priority
    cfg(0, 1, 2, 9, 3);
    clear_i = 1'b1; load_en_i = 1'b1; load_count_i = 4'd7; en_i = 1'b1;
    cyc(); expect_out("prio_clear", 2, 0, 0);
    clear_i = 1'b0;
    cyc(); expect_out("prio_load", 7, 0, 0);
    load_en_i = 1'b0; en_i = 1'b0;

    // Config error, then zero step
    cfg(0, 1, 10, 5, 3);
    en_i = 1'b1;
    #1 chk("cfg_err", int'(cfg_err_o), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(); expect_out("cfg_hold", 7, 0, 0);
    end
    cfg(0, 1, 2, 9, 0);
    #1 chk("cfg_ok", int'(cfg_err_o), 0);
    cyc(); expect_out("step0_hold", 7, 0, 0);
    cyc(); expect_out("step0_hold2", 7, 0, 0);
    en_i = 1'b0;

    // Out-of-range start going down: first step is a bound event
    cfg(0, 0, 3, 9, 1);
    load(1);
    en_i = 1'b1;
    cyc(); expect_out("oor_down", 9, 1, 0);
    en_i = 1'b0;

    // Async reset mid-count in RUN
    cfg(0, 1, 0, 15, 4);
    load(0);
    en_i = 1'b1;
    cyc(); expect_out("rst_s1", 4, 0, 0);
    cyc(); expect_out("rst_s2", 8, 0, 0);
    @(posedge clk_i); #3 rst_i = 1'b1;
    #1 expect_out("rst_async_run", 0, 0, 0);
    cyc(); rst_i = 1'b0;
    cyc(); expect_out("rst_resume", 4, 0, 0);
    en_i = 1'b0;

    // Async reset while in DONE
    cfg(2, 1, 0, 15, 5);
    load(12);
    en_i = 1'b1;
    cyc(); expect_out("rst_done_evt", 12, 1, 1);
    @(posedge clk_i); #3 rst_i = 1'b1;
    #1 expect_out("rst_async_done", 0, 0, 0);
    cyc(); rst_i = 1'b0;
    cyc(); expect_out("rst_done_resume", 5, 0, 0);
    en_i = 1'b0;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
